// File: rtl/decode_pkg.sv
// Shared opcode, funct, ALU and forward-select encodings for the ID stage.
// alu_decode maps an instruction's op/funct pair onto the ALU opcode.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIM = 6'h01;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_SYS  = 6'h0c;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [3:0] A_NOP  = 4'h0;
  localparam logic [3:0] A_SRA  = 4'h1;
  localparam logic [3:0] A_SRL  = 4'h2;
  localparam logic [3:0] A_ADD  = 4'h5;
  localparam logic [3:0] A_SUB  = 4'h6;
  localparam logic [3:0] A_AND  = 4'h7;
  localparam logic [3:0] A_OR   = 4'h8;
  localparam logic [3:0] A_XOR  = 4'h9;
  localparam logic [3:0] A_NOR  = 4'ha;
  localparam logic [3:0] A_SLT  = 4'hb;
  localparam logic [3:0] A_SLTU = 4'hc;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  function automatic logic [3:0] alu_decode(
    input logic [5:0] op,
    input logic [5:0] funct
  );
    logic [3:0] r;
    r = A_NOP;
    if (op == OP_RTYPE) begin
      case (funct)
        F_SRL, F_SRLV:  r = A_SRL;
        F_SRA:          r = A_SRA;
        F_ADD, F_ADDU:  r = A_ADD;
        F_SUB:          r = A_SUB;
        F_AND:          r = A_AND;
        F_OR:           r = A_OR;
        F_XOR:          r = A_XOR;
        F_NOR:          r = A_NOR;
        F_SLT:          r = A_SLT;
        F_SLTU:         r = A_SLTU;
        default:        r = A_NOP;
      endcase
    end else begin
      case (op)
        OP_REGIM, OP_SLTI:        r = A_SLT;
        OP_BEQ, OP_BNE, OP_XORI:  r = A_XOR;
        OP_ADDI, OP_ADDIU, OP_SW: r = A_ADD;
        OP_ANDI:                  r = A_AND;
        OP_ORI:                   r = A_OR;
        default:                  r = A_NOP;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational decode of an instruction word into ALU/memory controls,
// register read addresses and destination write-enable.
module id_decoder
  import decode_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SYS_RA = 2,
  parameter int SYS_RB = 4
) (
  input  logic [31:0]       ir,
  output logic [3:0]        aluop,
  output logic              dmload,
  output logic              dmstr,
  output logic              dmsel,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  output logic [REG_AW-1:0] rd,
  output logic              wr
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_r;
  logic       is_jal;
  logic       is_imm;
  logic       is_sys;

  assign op     = ir[31:26];
  assign funct  = ir[5:0];
  assign is_r   = op == OP_RTYPE;
  assign is_jal = op == OP_JAL;
  assign is_sys = is_r && funct == F_SYS;
  assign is_imm = op inside {OP_ADDI, OP_ADDIU, OP_SLTI,
                             OP_ANDI, OP_ORI, OP_XORI,
                             OP_LUI, OP_LW, OP_LBU};

  assign aluop  = alu_decode(op, funct);
  assign dmload = op inside {OP_LW, OP_LBU};
  assign dmstr  = op == OP_SW;
  assign dmsel  = dmload | dmstr;

  assign ra = is_sys ? REG_AW'(SYS_RA) : REG_AW'(ir[25:21]);
  assign rb = is_sys ? REG_AW'(SYS_RB) : REG_AW'(ir[20:16]);

  always_comb begin
    rd = '0;
    wr = 1'b0;
    unique case (1'b1)
      is_r: begin
        rd = REG_AW'(ir[15:11]);
        wr = !(funct inside {F_JR, F_SYS});
      end
      is_jal: begin
        rd = REG_AW'(31);
        wr = 1'b1;
      end
      is_imm: begin
        rd = REG_AW'(ir[20:16]);
        wr = 1'b1;
      end
      default: ;
    endcase
    // $0 is hardwired; never treat it as a writer
    if (rd == '0) wr = 1'b0;
  end

endmodule

// File: rtl/decode_hazard_stage.sv
// ID stage: decode, load-use detection, forward selects and the ID/EX
// register with flush/stall handshakes.
module decode_hazard_stage
  import decode_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter bit FWD_EN  = 1'b1,
  parameter int SYS_RA  = 2,
  parameter int SYS_RB  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [31:0]        if_ir,
  output logic               id_ready,
  input  logic               flush,
  input  logic               ex_stall,
  input  logic [REG_AW-1:0]  mem_rd,
  input  logic               mem_wr,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_dmload,
  output logic               ex_dmstr,
  output logic               ex_dmsel,
  output logic [REG_AW-1:0]  ex_ra,
  output logic [REG_AW-1:0]  ex_rb,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_wr,
  output logic [5:0]         ex_op,
  output logic [5:0]         ex_funct,
  output logic [15:0]        ex_imm,
  output logic [1:0]         ex_fwd_a,
  output logic [1:0]         ex_fwd_b
);

  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] aluop;
    logic               dmload;
    logic               dmstr;
    logic               dmsel;
    logic [REG_AW-1:0]  ra;
    logic [REG_AW-1:0]  rb;
    logic [REG_AW-1:0]  rd;
    logic               wr;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic [15:0]        imm;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
  } id_ex_t;

  id_ex_t q;
  id_ex_t nxt;

  logic [3:0]        d_aluop;
  logic              d_dmload;
  logic              d_dmstr;
  logic              d_dmsel;
  logic [REG_AW-1:0] d_ra;
  logic [REG_AW-1:0] d_rb;
  logic [REG_AW-1:0] d_rd;
  logic              d_wr;

  id_decoder #(
    .REG_AW (REG_AW),
    .SYS_RA (SYS_RA),
    .SYS_RB (SYS_RB)
  ) u_dec (
    .ir     (if_ir),
    .aluop  (d_aluop),
    .dmload (d_dmload),
    .dmstr  (d_dmstr),
    .dmsel  (d_dmsel),
    .ra     (d_ra),
    .rb     (d_rb),
    .rd     (d_rd),
    .wr     (d_wr)
  );

  logic ex_hit_a;
  logic ex_hit_b;
  logic mem_hit_a;
  logic mem_hit_b;
  logic load_use;
  logic raw_stall;

  assign ex_hit_a  = q.valid & q.wr & (q.rd == d_ra) & (d_ra != '0);
  assign ex_hit_b  = q.valid & q.wr & (q.rd == d_rb) & (d_rb != '0);
  assign mem_hit_a = mem_wr & (mem_rd == d_ra) & (d_ra != '0);
  assign mem_hit_b = mem_wr & (mem_rd == d_rb) & (d_rb != '0);

  assign load_use = q.valid & q.dmload & q.wr &
                    ((q.rd == d_ra) | (q.rd == d_rb));

  // without forwarding every EX-stage RAW has to wait it out
  assign raw_stall = FWD_EN ? load_use : (ex_hit_a | ex_hit_b);

  assign id_ready = flush | (!ex_stall & !raw_stall);

  always_comb begin
    nxt = '0;
    if (if_valid) begin
      nxt.valid  = 1'b1;
      nxt.aluop  = ALUOP_W'(d_aluop);
      nxt.dmload = d_dmload;
      nxt.dmstr  = d_dmstr;
      nxt.dmsel  = d_dmsel;
      nxt.ra     = d_ra;
      nxt.rb     = d_rb;
      nxt.rd     = d_rd;
      nxt.wr     = d_wr;
      nxt.op     = if_ir[31:26];
      nxt.funct  = if_ir[5:0];
      nxt.imm    = if_ir[15:0];
      if (FWD_EN) begin
        nxt.fwd_a = ex_hit_a ? FWD_EXM :
                    mem_hit_a ? FWD_MWB : FWD_RF;
        nxt.fwd_b = ex_hit_b ? FWD_EXM :
                    mem_hit_b ? FWD_MWB : FWD_RF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (ex_stall) begin
      q <= q;
    end else if (raw_stall) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign ex_valid  = q.valid;
  assign ex_aluop  = q.aluop;
  assign ex_dmload = q.dmload;
  assign ex_dmstr  = q.dmstr;
  assign ex_dmsel  = q.dmsel;
  assign ex_ra     = q.ra;
  assign ex_rb     = q.rb;
  assign ex_rd     = q.rd;
  assign ex_wr     = q.wr;
  assign ex_op     = q.op;
  assign ex_funct  = q.funct;
  assign ex_imm    = q.imm;
  assign ex_fwd_a  = q.fwd_a;
  assign ex_fwd_b  = q.fwd_b;

endmodule
